exe_mem_pipe_reg: RTL and testbench

Parametrised EXE->MEM pipeline register. Adds a valid/ready handshake, stall back-pressure, synchronous flush and an optional 2-entry skid buffer. It replaces the free-running register between the EXE and MEM stages so a stalled MEM stage (multi-cycle memory) no longer loses data. It also exports forwarding taps for the hazard/forwarding unit.

---
 rtl/exe_mem_pkg.sv | 40 ++++
 rtl/exe_mem_pipe_reg_slot.sv | 36 +++
 rtl/exe_mem_pipe_reg.sv | 159 +++++++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_pkg.sv
// Shared types for the EXE->MEM pipeline register.
// Holds the default widths, the payload layout, the occupancy state enum and
// a helper that maps the state to an entry count.
package exe_mem_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_REG_ADDR_W = 4;
    // wb_en, mem_r_en, mem_w_en
    localparam int unsigned CTRL_W         = 3;

    // Control bits sit in the MSBs so a slot can clear them with one part-select.
    typedef struct packed {
        logic                      wb_en;
        logic                      mem_r_en;
        logic                      mem_w_en;
        logic [DEF_DATA_W-1:0]     alu_result;
        logic [DEF_DATA_W-1:0]     st_val;
        logic [DEF_REG_ADDR_W-1:0] dest;
    } exe_mem_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(exe_mem_payload_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Number of entries held in each state.
    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/exe_mem_pipe_reg_slot.sv
// pipe_slot: one load-enabled payload register plus a valid bit.
// Ports: clk, rst_n (async active-low), flush (drops entry and clears the
// control bits in the MSBs), load (capture d, set valid), clear (drop valid,
// keep data), d/q payload, valid.
module pipe_slot
    import exe_mem_pkg::*;
#(
    parameter int unsigned W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // Flush beats load so a same-cycle input is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid               <= 1'b0;
            q[W-1 -: CTRL_W]    <= '0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer (SKID_EN=1, registered in_ready).
// Ports: clk, rst (async active-low), flush; EXE side in_valid/in_ready and the
// in_* payload; MEM side out_valid/out_ready and the out_* payload;
// occupancy (0..2); fwd_skid_* taps exposing the skid entry for forwarding.
module exe_mem_pipe_reg
    import exe_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter bit          SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic                  in_mem_w_en,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_st_val,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic                  out_mem_w_en,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_st_val,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [1:0]            occupancy,
    output logic                  fwd_skid_vld,
    output logic [REG_ADDR_W-1:0] fwd_skid_dest,
    output logic [DATA_W-1:0]     fwd_skid_data
);

    localparam int unsigned PW = CTRL_W + 2 * DATA_W + REG_ADDR_W;

    pipe_state_t   state, state_nxt;
    logic [PW-1:0] in_pl, main_d, main_q, skid_q;
    logic          main_valid, skid_valid;
    logic          in_fire, out_fire;
    logic          main_load, main_from_skid, main_clear, skid_load, skid_clear;

    assign in_pl    = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_result, in_st_val, in_dest};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and slot load/clear strobes
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_nxt = TWO;
                        skid_load = 1'b1;
                    end else if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt  = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;

            pipe_slot #(.W(PW)) u_skid (
                .clk   (clk),
                .rst_n (rst),
                .flush (flush),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_pl),
                .q     (skid_q),
                .valid (skid_valid)
            );

            // Registered ready: low only while both slots are full.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_nxt != TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            assign skid_q     = '0;
            assign skid_valid = 1'b0;
            assign in_ready   = !main_valid | out_ready;
        end
    endgenerate

    // Control bits are gated so an empty register never issues a MEM op.
    assign out_valid      = main_valid;
    assign {out_wb_en, out_mem_r_en, out_mem_w_en} =
        main_q[PW-1 -: CTRL_W] & {CTRL_W{main_valid}};
    assign out_alu_result = main_q[PW-CTRL_W-1 -: DATA_W];
    assign out_st_val     = main_q[REG_ADDR_W +: DATA_W];
    assign out_dest       = main_q[REG_ADDR_W-1:0];
    assign occupancy      = state_occupancy(state);

    // Loads are excluded: their data is not available until MEM.
    assign fwd_skid_vld  = skid_valid & skid_q[PW-1] & !skid_q[PW-2];
    assign fwd_skid_dest = skid_q[REG_ADDR_W-1:0];
    assign fwd_skid_data = skid_q[PW-CTRL_W-1 -: DATA_W];

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: a skid build (A) and a single-slot build (B)
// run in lockstep on shared stimulus, each checked against a queue model.
module tb_exe_mem_pipe_reg;
    import exe_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready;
    logic        in_wb, in_mr, in_mw;
    logic [31:0] in_alu, in_st;
    logic [3:0]  in_dest;

    logic        a_in_ready, a_ov, a_wb, a_mr, a_mw, a_fv;
    logic [31:0] a_alu, a_st, a_fdata;
    logic [3:0]  a_dest, a_fdest;
    logic [1:0]  a_occ;
    logic        b_in_ready, b_ov, b_wb, b_mr, b_mw, b_fv;
    logic [31:0] b_alu, b_st, b_fdata;
    logic [3:0]  b_dest, b_fdest;
    logic [1:0]  b_occ;

    int errors = 0;
    int checks = 0;

    exe_mem_payload_t qa[$];
    exe_mem_payload_t qb[$];
    exe_mem_payload_t last_a, last_b;

    always #5 clk = ~clk;

    exe_mem_pipe_reg #(.SKID_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_wb_en(in_wb), .in_mem_r_en(in_mr), .in_mem_w_en(in_mw),
        .in_alu_result(in_alu), .in_st_val(in_st), .in_dest(in_dest),
        .out_valid(a_ov), .out_ready(out_ready),
        .out_wb_en(a_wb), .out_mem_r_en(a_mr), .out_mem_w_en(a_mw),
        .out_alu_result(a_alu), .out_st_val(a_st), .out_dest(a_dest),
        .occupancy(a_occ), .fwd_skid_vld(a_fv), .fwd_skid_dest(a_fdest),
        .fwd_skid_data(a_fdata)
    );

    exe_mem_pipe_reg #(.SKID_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_wb_en(in_wb), .in_mem_r_en(in_mr), .in_mem_w_en(in_mw),
        .in_alu_result(in_alu), .in_st_val(in_st), .in_dest(in_dest),
        .out_valid(b_ov), .out_ready(out_ready),
        .out_wb_en(b_wb), .out_mem_r_en(b_mr), .out_mem_w_en(b_mw),
        .out_alu_result(b_alu), .out_st_val(b_st), .out_dest(b_dest),
        .occupancy(b_occ), .fwd_skid_vld(b_fv), .fwd_skid_dest(b_fdest),
        .fwd_skid_data(b_fdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare one DUT's registered outputs with its model queue.
    task automatic check_outs(input string who, input exe_mem_payload_t q[$],
                              input exe_mem_payload_t last, input bit has_skid,
                              input logic ov, input logic wb, input logic mr, input logic mw,
                              input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dest,
                              input logic [1:0] occ, input logic fv, input logic [3:0] fdest,
                              input logic [31:0] fdata);
        logic v;
        logic exp_fv;
        v = (q.size() > 0);
        check({who, ".out_valid"}, 64'(ov), 64'(v));
        check({who, ".out_wb_en"}, 64'(wb), 64'(v & last.wb_en));
        check({who, ".out_mem_r_en"}, 64'(mr), 64'(v & last.mem_r_en));
        check({who, ".out_mem_w_en"}, 64'(mw), 64'(v & last.mem_w_en));
        check({who, ".out_alu_result"}, 64'(alu), 64'(last.alu_result));
        check({who, ".out_st_val"}, 64'(st), 64'(last.st_val));
        check({who, ".out_dest"}, 64'(dest), 64'(last.dest));
        check({who, ".occupancy"}, 64'(occ), 64'(q.size()));
        exp_fv = has_skid && q.size() == 2 && q[1].wb_en && !q[1].mem_r_en;
        check({who, ".fwd_skid_vld"}, 64'(fv), 64'(exp_fv));
        if (q.size() == 2) begin
            check({who, ".fwd_skid_dest"}, 64'(fdest), 64'(q[1].dest));
            check({who, ".fwd_skid_data"}, 64'(fdata), 64'(q[1].alu_result));
        end
    endtask

    // One clock: check ready before the edge, advance the models, check outputs.
    task automatic step();
        logic rdy_a, rdy_b, of_a, of_b;
        exe_mem_payload_t p;
        rdy_a = (qa.size() < 2);
        rdy_b = (qb.size() == 0) || out_ready;
        #1;
        check("A.in_ready", 64'(a_in_ready), 64'(rdy_a));
        check("B.in_ready", 64'(b_in_ready), 64'(rdy_b));
        p = '{wb_en: in_wb, mem_r_en: in_mr, mem_w_en: in_mw,
              alu_result: in_alu, st_val: in_st, dest: in_dest};
        of_a = (qa.size() > 0) && out_ready;
        of_b = (qb.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (of_a) void'(qa.pop_front());
            if (in_valid && rdy_a) qa.push_back(p);
            if (of_b) void'(qb.pop_front());
            if (in_valid && rdy_b) qb.push_back(p);
        end
        if (qa.size() > 0) last_a = qa[0];
        if (qb.size() > 0) last_b = qb[0];
        #1;
        check_outs("A", qa, last_a, 1'b1, a_ov, a_wb, a_mr, a_mw, a_alu, a_st, a_dest,
                   a_occ, a_fv, a_fdest, a_fdata);
        check_outs("B", qb, last_b, 1'b0, b_ov, b_wb, b_mr, b_mw, b_alu, b_st, b_dest,
                   b_occ, b_fv, b_fdest, b_fdata);
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dest);
        in_valid = v;
        in_wb    = wb;
        in_mr    = mr;
        in_mw    = mw;
        in_alu   = alu;
        in_st    = st;
        in_dest  = dest;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        last_a = '0;
        last_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("A", qa, last_a, 1'b1, a_ov, a_wb, a_mr, a_mw, a_alu, a_st, a_dest,
                   a_occ, a_fv, a_fdest, a_fdata);
        check("A.reset_in_ready", 64'(a_in_ready), 64'(1));
        check("B.reset_in_ready", 64'(b_in_ready), 64'(1));
        rst = 1'b1;

        // Single push then idle
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0, 4'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step();
        step();

        // Back-to-back stream
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'(i & 1), 32'(i), 32'(i * 3), 4'(i));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step();

        // Stall into the skid, C waiting at the input, then release
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h1, 4'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 32'h2, 4'd2);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h33, 32'h3, 4'd4);
        step();
        step();
        out_ready = 1'b1;
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        repeat (3) step();

        // Flush while full with a simultaneous input
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h4, 4'd5);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 32'h5, 4'd6);
        step();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 4'd7);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        out_ready = 1'b1;
        step();

        // Async reset while both slots are full
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h66, 32'h6, 4'd8);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h7, 4'd9);
        step();
        check("A.occ_before_reset", 64'(a_occ), 64'(2));
        #1 rst = 1'b0;
        #1;
        check("A.rst_out_valid", 64'(a_ov), 64'(0));
        check("A.rst_out_alu", 64'(a_alu), 64'(0));
        check("A.rst_occupancy", 64'(a_occ), 64'(0));
        check("A.rst_in_ready", 64'(a_in_ready), 64'(1));
        check("A.rst_fwd_vld", 64'(a_fv), 64'(0));
        check("A.rst_fwd_data", 64'(a_fdata), 64'(0));
        check("B.rst_out_valid", 64'(b_ov), 64'(0));
        check("B.rst_out_wb", 64'(b_wb), 64'(0));
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Random traffic with back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 4'($urandom));
            step();
        end
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        out_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
